// File: rtl/if_read_burst_controller.sv
// Moves IFMap words from the FWFT input buffer into the scratchpad.
// Each grant moves BURST_LEN words, and set_status pulses once when a burst completes.
module if_read_burst_controller #(
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned PAD_DEPTH = 8,
    parameter int unsigned ADDR_W    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              IFMap_can_write,
    input  logic              buffer_valid,
    output logic              buffer_read_enable,
    output logic              pad_wen,
    output logic [ADDR_W-1:0] pad_waddr,
    output logic              pad_counter_enable,
    output logic              set_status,
    output logic              busy
);

    localparam int unsigned CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PAD_DEPTH - 1);
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] wptr;
    logic [CNT_W-1:0]  word_cnt;
    logic              xfer;

    // Pop and write happen in the same cycle the head word is valid, so no buffer underflow.
    assign xfer               = (state == XFER) & buffer_valid & IFMap_can_write;
    assign buffer_read_enable = xfer;
    assign pad_wen            = xfer;
    assign pad_counter_enable = xfer;
    assign pad_waddr          = wptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wptr       <= '0;
            word_cnt   <= '0;
            set_status <= 1'b0;
            busy       <= 1'b0;
        end else if (clear) begin
            // A word written in this cycle is kept, but the burst is dropped without status.
            state      <= IDLE;
            wptr       <= '0;
            word_cnt   <= '0;
            set_status <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    set_status <= 1'b0;
                    word_cnt   <= '0;
                    if (IFMap_can_write && buffer_valid) begin
                        state <= XFER;
                        busy  <= 1'b1;
                    end else begin
                        busy  <= 1'b0;
                    end
                end
                XFER: begin
                    if (xfer) begin
                        wptr     <= (wptr == LAST_ADDR) ? '0 : wptr + ADDR_W'(1);
                        word_cnt <= word_cnt + CNT_W'(1);
                        if (word_cnt == LAST_CNT) begin
                            state      <= DONE;
                            set_status <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    word_cnt   <= '0;
                    set_status <= 1'b0;
                    busy       <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    word_cnt   <= '0;
                    set_status <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_read_burst_controller.sv
// Bench for if_read_burst_controller with BURST_LEN=4, PAD_DEPTH=6, plus a BURST_LEN=1 instance.
// The bench uses per-cycle vectors, a write-address scoreboard, and hand sequences for reset and cadence.
module tb_if_read_burst_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic       can = 1'b0;
    logic       valid = 1'b0;
    logic       pop, wen, cnt_en, set_st, busy;
    logic [2:0] waddr;

    logic       b_can = 1'b0;
    logic       b_valid = 1'b0;
    logic       b_pop, b_wen, b_cnt_en, b_set, b_busy;
    logic [2:0] b_waddr;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic       clr, cw, bv;
        logic       e_pop;
        logic [2:0] e_addr;
        logic       e_set, e_busy;
    } vec_t;

    vec_t vecs[$];
    int   sb[$];

    always #5 clk = ~clk;

    if_read_burst_controller #(.BURST_LEN(4), .PAD_DEPTH(6), .ADDR_W(3)) dut (
        .clk(clk), .rst(rst), .clear(clear), .IFMap_can_write(can), .buffer_valid(valid),
        .buffer_read_enable(pop), .pad_wen(wen), .pad_waddr(waddr),
        .pad_counter_enable(cnt_en), .set_status(set_st), .busy(busy)
    );

    if_read_burst_controller #(.BURST_LEN(1), .PAD_DEPTH(6), .ADDR_W(3)) dut_b1 (
        .clk(clk), .rst(rst), .clear(clear), .IFMap_can_write(b_can), .buffer_valid(b_valid),
        .buffer_read_enable(b_pop), .pad_wen(b_wen), .pad_waddr(b_waddr),
        .pad_counter_enable(b_cnt_en), .set_status(b_set), .busy(b_busy)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic void add(input logic clr, cw, bv, e_pop, input logic [2:0] e_addr,
                                input logic e_set, e_busy);
        vec_t v;
        v.clr = clr; v.cw = cw; v.bv = bv; v.e_pop = e_pop;
        v.e_addr = e_addr; v.e_set = e_set; v.e_busy = e_busy;
        vecs.push_back(v);
    endfunction

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        clear = v.clr; can = v.cw; valid = v.bv;
        #1;
        if (v.e_pop) sb.push_back(int'(v.e_addr));
        check($sformatf("v%0d.pop", idx), int'(pop), int'(v.e_pop));
        check($sformatf("v%0d.wen", idx), int'(wen), int'(v.e_pop));
        check($sformatf("v%0d.cnt_en", idx), int'(cnt_en), int'(v.e_pop));
        check($sformatf("v%0d.waddr", idx), int'(waddr), int'(v.e_addr));
        check($sformatf("v%0d.set_status", idx), int'(set_st), int'(v.e_set));
        check($sformatf("v%0d.busy", idx), int'(busy), int'(v.e_busy));
        if (wen) begin
            if (sb.size() == 0) check($sformatf("v%0d.sb_extra_write", idx), 1, 0);
            else check($sformatf("v%0d.sb_addr", idx), int'(waddr), sb.pop_front());
        end
    endtask

    initial begin
        int npops;
        int set_at;

        // Burst 1 and burst 2 back to back; the second wraps at depth 6.
        add(0,1,1, 0,0,0,0); add(0,1,1, 1,0,0,1); add(0,1,1, 1,1,0,1); add(0,1,1, 1,2,0,1);
        add(0,1,1, 1,3,0,1); add(0,1,1, 0,4,1,1); add(0,1,1, 0,4,0,0); add(0,1,1, 1,4,0,1);
        add(0,1,1, 1,5,0,1); add(0,1,1, 1,0,0,1); add(0,1,1, 1,1,0,1); add(0,0,0, 0,2,1,1);
        add(0,0,0, 0,2,0,0);
        // Clear while idle, then buffer empty for 3 cycles after word 2.
        add(1,0,0, 0,2,0,0); add(0,1,1, 0,0,0,0); add(0,1,1, 1,0,0,1); add(0,1,1, 1,1,0,1);
        add(0,1,0, 0,2,0,1); add(0,1,0, 0,2,0,1); add(0,1,0, 0,2,0,1); add(0,1,1, 1,2,0,1);
        add(0,1,1, 1,3,0,1); add(0,0,0, 0,4,1,1); add(0,0,0, 0,4,0,0);
        // can_write drops on word 3 while the buffer remains valid.
        add(0,1,1, 0,4,0,0); add(0,1,1, 1,4,0,1); add(0,1,1, 1,5,0,1); add(0,0,1, 0,0,0,1);
        add(0,0,1, 0,0,0,1); add(0,1,1, 1,0,0,1); add(0,1,1, 1,1,0,1); add(0,0,0, 0,2,1,1);
        add(0,0,0, 0,2,0,0);
        // Clear on the last word: the word is written, with no status, and pointer restarts at 0.
        add(0,1,1, 0,2,0,0); add(0,1,1, 1,2,0,1); add(0,1,1, 1,3,0,1); add(0,1,1, 1,4,0,1);
        add(1,1,1, 1,5,0,1); add(0,1,1, 0,0,0,0); add(0,1,1, 1,0,0,1); add(0,1,1, 1,1,0,1);

        // Reset state
        #2;
        check("rst.pop", int'(pop), 0);
        check("rst.waddr", int'(waddr), 0);
        check("rst.set_status", int'(set_st), 0);
        check("rst.busy", int'(busy), 0);
        check("rst.b1_pop", int'(b_pop), 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) apply(vecs[i], i);
        check("sb.pending", sb.size(), 0);

        // Async reset mid-burst after 2 words; outputs drop in the same cycle.
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst.pop", int'(pop), 0);
        check("midrst.waddr", int'(waddr), 0);
        check("midrst.busy", int'(busy), 0);
        check("midrst.set_status", int'(set_st), 0);
        @(negedge clk);
        rst = 1'b0; clear = 1'b0; can = 1'b1; valid = 1'b1;
        npops = 0;
        set_at = -1;
        for (int k = 0; k < 12 && set_at < 0; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            if (pop) begin
                check($sformatf("postrst.addr%0d", npops), int'(waddr), npops);
                npops++;
            end
            if (set_st) set_at = k;
        end
        check("postrst.set_cycle", set_at, 5);
        check("postrst.pops", npops, 4);

        // BURST_LEN=1 gives a 3-cycle cadence: grant, pop, status.
        @(negedge clk);
        can = 1'b0; valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; b_can = 1'b1; b_valid = 1'b1;
        for (int k = 0; k < 9; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            check($sformatf("b1.pop%0d", k), int'(b_pop), int'(k % 3 == 1));
            check($sformatf("b1.set%0d", k), int'(b_set), int'(k % 3 == 2));
            if (k % 3 == 1) check($sformatf("b1.addr%0d", k), int'(b_waddr), k / 3);
        end
        b_can = 1'b0; b_valid = 1'b0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
